com_tx_sched: RTL and testbench

//  Scheduler in front of com_tx. Arbitrates handshake replies, status packets and data

---
 rtl/com_tx_sched.sv | 213 +++++++++++++++++++++
 tb/tb_com_tx_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/com_tx_sched.sv
// com_tx_sched: frame scheduler in front of com_tx.
// - Arbitrates handshake replies, status packets and data packets.
// - Loads btype/ram_init/ram_rlen and runs the fs/fd handshake.
// - Keeps the DATA0/DATA1 toggle and enforces an inter-frame gap.
// Optional feature: define COM_TX_TIMEOUT_EN to bound the SEND state by TIMEOUT cycles.
module com_tx_sched #(
  parameter int unsigned IFG       = 4,
  parameter logic [11:0] LINK_INIT = 12'h000,
  parameter logic [11:0] LINK_LEN  = 12'h004,
  parameter logic [11:0] TYPE_INIT = 12'h010,
  parameter logic [11:0] TYPE_LEN  = 12'h004,
  parameter logic [11:0] TEMP_INIT = 12'h020,
  parameter logic [11:0] TEMP_LEN  = 12'h002,
  parameter logic [11:0] TIMEOUT   = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_req,
  input  logic [1:0]  hs_type,
  output logic        hs_ack,
  input  logic [2:0]  st_req,
  output logic [2:0]  st_ack,
  input  logic        dat_req,
  input  logic [11:0] dat_init,
  input  logic [11:0] dat_rlen,
  output logic        dat_ack,
  input  logic        tog_clr,
  output logic        tx_fs,
  input  logic        tx_fd,
  output logic [3:0]  tx_btype,
  output logic [11:0] tx_ram_init,
  output logic [11:0] tx_ram_rlen,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam logic [4:0] IFG_N = 5'(IFG);

  logic [2:0]  state_q, state_d;
  logic [3:0]  btype_q, btype_d;
  logic [11:0] init_q, init_d;
  logic [11:0] rlen_q, rlen_d;
  logic        is_dat_q, is_dat_d;
  logic        tog_q, tog_d;
  logic        done_q, done_d;
  logic [3:0]  gap_q, gap_d;
  logic        gnt_hs, gnt_dat;
  logic [2:0]  gnt_st;
  logic        in_arb, gap_last;

`ifdef COM_TX_TIMEOUT_EN
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`else
  // TIMEOUT only matters when the SEND timeout is compiled in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Handshake type to btype; the reserved code 00 is sent as a NAK.
  function automatic logic [3:0] hs_btype(input logic [1:0] t);
    case (t)
      2'b01:   hs_btype = 4'b0001;
      2'b11:   hs_btype = 4'b0011;
      default: hs_btype = 4'b0010;
    endcase
  endfunction

  // Fixed-priority winner among the live requests: hs > link > type > temp > data.
  always_comb begin
    gnt_hs    = hs_req;
    gnt_st[0] = !hs_req && st_req[0];
    gnt_st[1] = !hs_req && !st_req[0] && st_req[1];
    gnt_st[2] = !hs_req && !st_req[0] && !st_req[1] && st_req[2];
    gnt_dat   = !hs_req && (st_req == 3'b000) && dat_req;
  end

  assign in_arb      = (state_q == S_ARB);
  assign gap_last    = (({1'b0, gap_q} + 5'd1) >= IFG_N);
  assign hs_ack      = in_arb && gnt_hs;
  assign st_ack      = in_arb ? gnt_st : 3'b000;
  assign dat_ack     = in_arb && gnt_dat;
  assign tx_fs       = (state_q == S_SEND);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign tx_btype    = btype_q;
  assign tx_ram_init = init_q;
  assign tx_ram_rlen = rlen_q;
`ifdef COM_TX_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

  // Next-state logic for the scheduler FSM, frame descriptor and toggle.
  always_comb begin
    state_d  = state_q;
    btype_d  = btype_q;
    init_d   = init_q;
    rlen_d   = rlen_q;
    is_dat_d = is_dat_q;
    tog_d    = tog_q;
    done_d   = 1'b0;
    gap_d    = gap_q;
`ifdef COM_TX_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (hs_req || (st_req != 3'b000) || dat_req) state_d = S_ARB;
      end
      S_ARB: begin
        gap_d   = 4'd0;
        state_d = S_LOAD;
        if (gnt_hs) begin
          btype_d = hs_btype(hs_type); init_d = 12'h000; rlen_d = 12'h000; is_dat_d = 1'b0;
        end else if (gnt_st[0]) begin
          btype_d = 4'b1000; init_d = LINK_INIT; rlen_d = LINK_LEN; is_dat_d = 1'b0;
        end else if (gnt_st[1]) begin
          btype_d = 4'b1001; init_d = TYPE_INIT; rlen_d = TYPE_LEN; is_dat_d = 1'b0;
        end else if (gnt_st[2]) begin
          btype_d = 4'b1010; init_d = TEMP_INIT; rlen_d = TEMP_LEN; is_dat_d = 1'b0;
        end else if (gnt_dat) begin
          // The PID is fixed here; later toggle changes do not affect this frame.
          btype_d  = tog_q ? 4'b1110 : 4'b1101;
          init_d   = dat_init;
          rlen_d   = dat_rlen;
          is_dat_d = 1'b1;
          // An empty data packet is granted but never reaches com_tx.
          if (dat_rlen == 12'h000) state_d = S_GAP;
        end else begin
          // Request vanished before arbitration; nothing to serve.
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
`ifdef COM_TX_TIMEOUT_EN
        cnt_d   = 12'h000;
`endif
      end
      S_SEND: begin
        if (tx_fd) begin
          done_d  = 1'b1;
          state_d = S_REL;
          if (is_dat_q) tog_d = !tog_q;
        end
`ifdef COM_TX_TIMEOUT_EN
        else if (cnt_q == (TIMEOUT - 12'd1)) begin
          err_d   = 1'b1;
          state_d = S_REL;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
`endif
      end
      S_REL: begin
        if (!tx_fd) begin
          state_d = S_GAP;
          gap_d   = 4'd0;
        end
      end
      S_GAP: begin
        if (gap_last) state_d = S_IDLE;
        else          gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // A clear request overrides any flip in the same cycle.
    if (tog_clr) tog_d = 1'b0;
  end

  // State and descriptor registers; reset returns to IDLE with DATA0 pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      btype_q  <= 4'b0000;
      init_q   <= 12'h000;
      rlen_q   <= 12'h000;
      is_dat_q <= 1'b0;
      tog_q    <= 1'b0;
      done_q   <= 1'b0;
      gap_q    <= 4'd0;
`ifdef COM_TX_TIMEOUT_EN
      cnt_q    <= 12'h000;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      btype_q  <= btype_d;
      init_q   <= init_d;
      rlen_q   <= rlen_d;
      is_dat_q <= is_dat_d;
      tog_q    <= tog_d;
      done_q   <= done_d;
      gap_q    <= gap_d;
`ifdef COM_TX_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_com_tx_sched.sv
// Bench for com_tx_sched: frame scoreboard checked at every tx_fs rise,
// plus directed latency, gap, toggle, empty-packet and reset checks.
module tb_com_tx_sched;

  localparam int IFG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_req = 1'b0;
  logic [1:0]  hs_type = 2'b00;
  logic        hs_ack;
  logic [2:0]  st_req = 3'b000;
  logic [2:0]  st_ack;
  logic        dat_req = 1'b0;
  logic [11:0] dat_init = 12'h000;
  logic [11:0] dat_rlen = 12'h000;
  logic        dat_ack;
  logic        tog_clr = 1'b0;
  logic        tx_fs;
  logic        tx_fd = 1'b0;
  logic [3:0]  tx_btype;
  logic [11:0] tx_ram_init;
  logic [11:0] tx_ram_rlen;
  logic        busy;
  logic        done;
  logic        err;

  com_tx_sched #(.IFG(IFG), .TIMEOUT(12'd16)) dut (
    .clk(clk), .rst(rst),
    .hs_req(hs_req), .hs_type(hs_type), .hs_ack(hs_ack),
    .st_req(st_req), .st_ack(st_ack),
    .dat_req(dat_req), .dat_init(dat_init), .dat_rlen(dat_rlen), .dat_ack(dat_ack),
    .tog_clr(tog_clr),
    .tx_fs(tx_fs), .tx_fd(tx_fd),
    .tx_btype(tx_btype), .tx_ram_init(tx_ram_init), .tx_ram_rlen(tx_ram_rlen),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bt;
    logic [11:0] init;
    logic [11:0] rlen;
  } frame_t;

  frame_t sb[$];
  frame_t exp_f;
  int     n_total = 0;
  int     n_bad = 0;
  int     fs_rises = 0;
  int     done_cnt = 0;
  logic   prev_fs = 1'b0;
  logic   m_tog = 1'b0;
  logic   fd_en = 1'b1;
  int     fs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] bt, input logic [11:0] i, input logic [11:0] r);
    frame_t f;
    f.bt = bt; f.init = i; f.rlen = r;
    sb.push_back(f);
  endtask

  // Scoreboard: every frame start must match the oldest expected descriptor.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (tx_fs && !prev_fs) begin
      fs_rises++;
      if (sb.size() == 0) chk("sb_unexpected_fs", sb.size(), 1);
      else begin
        exp_f = sb.pop_front();
        chk("sb_btype", tx_btype, exp_f.bt);
        chk("sb_init", tx_ram_init, exp_f.init);
        chk("sb_rlen", tx_ram_rlen, exp_f.rlen);
      end
    end
    prev_fs = tx_fs;
  end

  // com_tx stand-in: raise fd after 3 fs cycles, drop it once fs falls.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_fd && !tx_fs) tx_fd = 1'b0;
      else if (!tx_fs) fs_cnt = 0;
      else if (fd_en) begin
        fs_cnt++;
        if (fs_cnt >= 3) begin tx_fd = 1'b1; fs_cnt = 0; end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // kind: 0 hs, 1..3 st bit kind-1, 4 data
  task automatic wait_ack(input string tag, input int kind);
    logic [4:0] exp, vec;
    bit found;
    int sh;
    sh = (kind == 0) ? 4 : (kind == 4) ? 0 : kind;
    exp = 5'b00001 << sh;
    found = 0;
    vec = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      vec = {hs_ack, st_ack, dat_ack};
      if ((vec & exp) != 5'b0) found = 1;
    end
    chk(tag, vec, exp);
    @(posedge clk); #1;
    if (kind == 0) hs_req = 1'b0;
    else if (kind == 4) dat_req = 1'b0;
    else st_req[kind-1] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk(tag, busy, 0);
  endtask

  task automatic send_dat(input string tag, input logic [11:0] i, input logic [11:0] r);
    if (r != 12'h000) begin
      push(m_tog ? 4'b1110 : 4'b1101, i, r);
      m_tog = ~m_tog;
    end
    dat_init = i; dat_rlen = r; dat_req = 1'b1;
    wait_ack({tag, "_ack"}, 4);
    wait_idle({tag, "_idle"});
  endtask

  task automatic pulse_clr();
    @(negedge clk); tog_clr = 1'b1;
    @(negedge clk); tog_clr = 1'b0;
    m_tog = 1'b0;
  endtask

  initial begin
    int n, d0, f0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {hs_ack, st_ack, dat_ack, tx_fs, done, err, tx_btype, tx_ram_init, tx_ram_rlen},
        '0);
    rst = 1'b0;

    // T1: handshake ACK latency, done pulse, inter-frame gap
    @(negedge clk);
    push(4'b0001, 12'h000, 12'h000);
    hs_type = 2'b01; hs_req = 1'b1;
    @(negedge clk);
    chk("t1_ack_p1", {hs_ack, st_ack, dat_ack}, 5'b10000);
    @(posedge clk); #1 hs_req = 1'b0;
    @(negedge clk);
    chk("t1_load_p2", {tx_fs, tx_btype}, {1'b0, 4'b0001});
    @(negedge clk);
    chk("t1_fs_p3", tx_fs, 1);
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    chk("t1_done", done, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 50);
    chk("t1_gap", n, IFG + 1);
    chk("t1_done_cnt", done_cnt, 1);

    // T2: link before temp
    push(4'b1000, 12'h000, 12'h004);
    push(4'b1010, 12'h020, 12'h002);
    st_req = 3'b101;
    wait_ack("t2_link_ack", 1);
    wait_ack("t2_temp_ack", 3);
    wait_idle("t2_idle");

    // T3: DATA0/DATA1 alternation, then toggle clear
    for (int k = 0; k < 3; k++) send_dat("t3_dat", 12'h100, 12'd40);
    pulse_clr();
    send_dat("t3_clr_a", 12'h100, 12'd40);
    pulse_clr();
    send_dat("t3_clr_b", 12'h100, 12'd40);

    // T4: simultaneous hs (reserved type 00), type status, data
    @(negedge clk);
    push(4'b0010, 12'h000, 12'h000);
    push(4'b1001, 12'h010, 12'h004);
    push(m_tog ? 4'b1110 : 4'b1101, 12'h200, 12'h008);
    m_tog = ~m_tog;
    hs_type = 2'b00; dat_init = 12'h200; dat_rlen = 12'h008;
    hs_req = 1'b1; st_req = 3'b010; dat_req = 1'b1;
    wait_ack("t4_hs_ack", 0);
    wait_ack("t4_type_ack", 2);
    wait_ack("t4_dat_ack", 4);
    wait_idle("t4_idle");

    // T5: empty data packet
    d0 = done_cnt; f0 = fs_rises;
    send_dat("t5_zero", 12'h300, 12'h000);
    chk("t5_no_fs", fs_rises, f0);
    chk("t5_no_done", done_cnt, d0);
    send_dat("t5_after", 12'h300, 12'h010);

    // T6: reset in SEND
    fd_en = 1'b0;
    @(negedge clk);
    push(4'b0011, 12'h000, 12'h000);
    hs_type = 2'b11; hs_req = 1'b1;
    wait_ack("t6_ack", 0);
    n = 0;
    while (!tx_fs && n < 50) begin @(negedge clk); n++; end
    chk("t6_in_send", tx_fs, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_fs", tx_fs, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    m_tog = 1'b0;
    fd_en = 1'b1;
    send_dat("t6_after_rst", 12'h040, 12'h020);

`ifdef COM_TX_TIMEOUT_EN
    // Timeout with fd held low
    fd_en = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    push(m_tog ? 4'b1110 : 4'b1101, 12'h080, 12'h004);
    dat_init = 12'h080; dat_rlen = 12'h004; dat_req = 1'b1;
    wait_ack("to_ack", 4);
    n = 0;
    while (!tx_fs && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 100);
    chk("to_err_cycle", n, 16);
    chk("to_fs_low", tx_fs, 0);
    fd_en = 1'b1;
    wait_idle("to_idle");
    chk("to_no_done", done_cnt, d0);
    send_dat("to_tog_kept", 12'h080, 12'h004);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
